// File: rtl/uart_line_ctrl_if.sv
// Bus between the UART RX/TX cores, the CPU IO decoder and the line controller.
// The master side drives the controller inputs; the slave side is the controller itself.
interface uart_line_ctrl_if #(
    parameter int WIDTH = 32
);
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [7:0]       tx_data;
    logic             tx_start;
    logic             tx_busy;
    logic [WIDTH-1:0] num_value;
    logic             num_ready;
    logic             num_ack;
    logic [3:0]       err_flags;
    logic             err_clr;

    modport master (
        output rx_data, rx_valid, tx_busy, num_ack, err_clr,
        input  tx_data, tx_start, num_value, num_ready, err_flags
    );

    modport slave (
        input  rx_data, rx_valid, tx_busy, num_ack, err_clr,
        output tx_data, tx_start, num_value, num_ready, err_flags
    );
endinterface

// File: rtl/uart_line_ctrl.sv
// UART line controller: turns received ASCII digits into decimal values terminated
// by LF, presents each value to the CPU with a ready/ack handshake, keeps sticky
// error flags and optionally echoes every received byte through the UART TX core.
module uart_line_ctrl #(
    parameter int WIDTH   = 32,
    parameter bit ECHO_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    uart_line_ctrl_if.slave   bus
);
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;
    localparam logic [WIDTH+3:0] TEN_W = {{WIDTH{1'b0}}, 4'd10};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] num_value_q, num_value_d;
    logic             num_ready_q, num_ready_d;
    logic [3:0]       err_q, err_d;
    logic             echo_full_q, echo_full_d;
    logic [7:0]       echo_byte_q, echo_byte_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q, tx_data_d;

    logic             is_digit_s;
    logic [WIDTH+3:0] acc_next_s;
    logic             acc_ovf_s;
    logic             line_done_s;
    logic             echo_issue_s;
    logic [3:0]       new_err_s;

    // Digit value is the low nibble of '0'..'9'; the wide product cannot wrap.
    assign is_digit_s = (bus.rx_data >= CH_0) && (bus.rx_data <= CH_9);
    assign acc_next_s = ({4'b0000, acc_q} * TEN_W) + {{WIDTH{1'b0}}, bus.rx_data[3:0]};
    assign acc_ovf_s  = (acc_next_s[WIDTH+3:WIDTH] != 4'b0000);

    // Next-state logic: line parser, output handshake, echo buffer and error flags.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        num_value_d  = num_value_q;
        num_ready_d  = num_ready_q;
        echo_full_d  = echo_full_q;
        echo_byte_d  = echo_byte_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        line_done_s  = 1'b0;
        echo_issue_s = 1'b0;
        new_err_s    = 4'b0000;

        if (bus.rx_valid) begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (is_digit_s) begin
                        if (acc_ovf_s) begin
                            new_err_s[0] = 1'b1;
                            state_d      = ST_DISCARD;
                        end else begin
                            acc_d   = acc_next_s[WIDTH-1:0];
                            state_d = ST_ACCUM;
                        end
                    end else if (bus.rx_data == CH_LF) begin
                        // An LF on an empty line is a no-op.
                        if (state_q == ST_ACCUM) begin
                            line_done_s = 1'b1;
                            state_d     = ST_IDLE;
                            acc_d       = {WIDTH{1'b0}};
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (bus.rx_data == CH_CR) begin
                        state_d = state_q;
                    end else begin
                        new_err_s[1] = 1'b1;
                        state_d      = ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (bus.rx_data == CH_LF) begin
                        state_d = ST_IDLE;
                        acc_d   = {WIDTH{1'b0}};
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    acc_d   = {WIDTH{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // A completed line replaces the held value only if the CPU has taken it.
        if (line_done_s) begin
            if (!num_ready_q || bus.num_ack) begin
                num_value_d = acc_q;
                num_ready_d = 1'b1;
            end else begin
                new_err_s[2] = 1'b1;
            end
        end else if (bus.num_ack && num_ready_q) begin
            num_ready_d = 1'b0;
        end else begin
            num_ready_d = num_ready_q;
        end

        // Issue waits one cycle after a start so TX busy has time to rise.
        if (ECHO_EN) begin
            echo_issue_s = echo_full_q && !bus.tx_busy && !tx_start_q;
            if (echo_issue_s) begin
                tx_start_d  = 1'b1;
                tx_data_d   = echo_byte_q;
                echo_full_d = 1'b0;
            end else begin
                tx_start_d = 1'b0;
            end
            if (bus.rx_valid) begin
                if (!echo_full_q || echo_issue_s) begin
                    echo_byte_d = bus.rx_data;
                    echo_full_d = 1'b1;
                end else begin
                    new_err_s[3] = 1'b1;
                end
            end else begin
                echo_byte_d = echo_byte_q;
            end
        end else begin
            tx_start_d  = 1'b0;
            tx_data_d   = 8'h00;
            echo_full_d = 1'b0;
            echo_byte_d = 8'h00;
        end

        // A clear loses against an error raised in the same cycle.
        if (bus.err_clr) begin
            err_d = new_err_s;
        end else begin
            err_d = err_q | new_err_s;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= {WIDTH{1'b0}};
            num_value_q <= {WIDTH{1'b0}};
            num_ready_q <= 1'b0;
            err_q       <= 4'b0000;
            echo_full_q <= 1'b0;
            echo_byte_q <= 8'h00;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            num_value_q <= num_value_d;
            num_ready_q <= num_ready_d;
            err_q       <= err_d;
            echo_full_q <= echo_full_d;
            echo_byte_q <= echo_byte_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.num_value = num_value_q;
    assign bus.num_ready = num_ready_q;
    assign bus.err_flags = err_q;
endmodule

// File: doc/uart_line_ctrl.md
Name: uart_line_ctrl

Overview:
- Sequences the byte stream from the SoC's UART receiver into decimal-number lines for the CPU.
- Accumulates ASCII digits, completes a value on LF (0x0A), and holds it in a CPU-visible output register with a ready/ack handshake.
- Optionally echoes every received byte back through the UART transmitter using its start/busy handshake.
- Sits between the UART RX/TX cores and the CPU's memory-mapped IO decoder.

Parameters:
- WIDTH, 32, width of the accumulated and output value in bits.
- ECHO_EN, 1, 1 = echo received bytes to TX; 0 = tx_start tied low and echo logic removed.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from UART RX; valid only while rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte.
- tx_data  out  8  byte to UART TX; stable while tx_start=1.
- tx_start  out  1  one-cycle strobe requesting transmission of tx_data.
- tx_busy  in  1  UART TX busy; rises the cycle after tx_start and stays high until the frame ends.
- num_value  out  WIDTH  last completed value; held until replaced.
- num_ready  out  1  num_value holds an unacknowledged value.
- num_ack  in  1  CPU consumed num_value; ignored when num_ready=0.
- err_flags  out  4  sticky flags: [0] overflow, [1] bad_char, [2] overrun, [3] echo_drop.
- err_clr  in  1  clears all err_flags next cycle; a same-cycle new error wins and stays set.

Behaviour:
- Reset values: num_value=0, num_ready=0, err_flags=0, tx_start=0, tx_data=0, acc=0, echo buffer empty, state=IDLE.
- Reset mid-line discards the partial value, any pending echo, and any held num_value.
- Accumulator FSM states: IDLE (no digits yet), ACCUM (at least one digit), DISCARD (error; skip to LF). The FSM acts only on cycles with rx_valid=1.
- Digit, 0x30–0x39: next = acc*10 + (rx_data-0x30), computed in WIDTH+4 bits.
  - If next > 2^WIDTH-1: set overflow, go to DISCARD.
  - Otherwise acc=next, go to ACCUM.
  - In DISCARD, digits are ignored.
- CR (0x0D): ignored in all states.
- LF in ACCUM: completes the value and the FSM returns to IDLE with acc=0.
  - If num_ready=0, or num_ack=1 in the same cycle: num_value=acc and num_ready=1 on the next edge. Latency is 1 cycle from the rx_valid of the LF.
  - Otherwise set overrun; the new value is dropped and the old num_value is kept.
- LF in IDLE (empty line): no effect.
- LF in DISCARD: go to IDLE, acc=0; the flags stay set.
- Any other byte: in IDLE or ACCUM, set bad_char and go to DISCARD; in DISCARD, ignored.
- Handshake: num_ack with num_ready=1 clears num_ready next cycle unless a value completes in the same cycle.
- Echo (ECHO_EN=1): every rx byte, including CR, LF and bad bytes, is offered to a 1-entry echo buffer.
  - Buffer empty: the byte is stored on the next edge.
  - Buffer full and not draining that cycle: byte dropped, echo_drop set.
- Echo issue rules:
  - tx_start=1 for exactly one cycle when the buffer is full, tx_busy=0, and tx_start was 0 in the previous cycle (covers TX busy latency).
  - tx_data = buffered byte; the buffer empties on the same edge that tx_start is asserted.
  - A byte arriving in the issue cycle refills the buffer without a drop.
- Simultaneous events: err_clr plus a new error leaves the new flag set and clears the others.

Test Plan:
- "5","7","8",LF with 150-cycle gaps -> num_value=578 (0x242), num_ready=1 one cycle after the LF strobe; num_ack -> num_ready=0 next cycle.
- "1","4",CR,LF -> num_value=14; err_flags=0. A lone LF before it leaves num_ready=0.
- "4294967296",LF (WIDTH=32) -> overflow=1, num_ready stays 0; then "7",LF -> num_value=7.
- "1","a","2",LF -> bad_char=1, no value; err_clr -> err_flags=0; "9",LF -> num_value=9.
- "3",LF,"5",LF with no ack -> num_value=3, overrun=1. Repeat with num_ack in the second LF's cycle -> num_value=5, num_ready=1, overrun=0.
- Echo with tx_busy held high 200 cycles while "1","2" arrive -> one tx_start with tx_data=0x31 after busy falls, echo_drop=1. Assert reset mid-line "12" -> all outputs return to reset values; "6",LF -> num_value=6.
